// File: rtl/ripple_cnt_ctrl_pkg.sv
// ripple_cnt_ctrl_pkg: op encodings, state enums and timing helper for the ripple counter sequencer
package ripple_cnt_ctrl_pkg;
    typedef enum logic [1:0] {
        OP_COUNT = 2'b00,
        OP_ZERO  = 2'b01,
        OP_HOLD  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;
    typedef enum logic [2:0] {S_IDLE, S_HIGH, S_SETTLE, S_CHECK, S_FIN} state_t;
    typedef enum logic [1:0] {G_IDLE, G_HI, G_ST} gph_t;
    function automatic int pulse_lat(input int hi, input int st);
        return hi + st + 1;
    endfunction
endpackage

// File: rtl/ripple_cnt_pulse_gen.sv
// ripple_cnt_pulse_gen: times one cnt_clk pulse (high phase, then settle) and flags the sample cycle
module ripple_cnt_pulse_gen
    import ripple_cnt_ctrl_pkg::*;
#(
    parameter int PULSE_HI = 1,
    parameter int SETTLE   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    output logic cnt_clk,
    output logic phase_end,
    output logic sample_now
);
    localparam int TW = $clog2((PULSE_HI > SETTLE ? PULSE_HI : SETTLE) + 1);
    gph_t ph;
    logic [TW-1:0] tmr;
    assign phase_end = ph != G_IDLE && tmr == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            ph         <= G_IDLE;
            tmr        <= '0;
            cnt_clk    <= 1'b0;
            sample_now <= 1'b0;
        end else begin
            sample_now <= ph == G_ST && tmr == '0;
            if (fire) begin
                ph      <= G_HI;
                tmr     <= TW'(PULSE_HI - 1);
                cnt_clk <= 1'b1;
            end else if (phase_end) begin
                ph      <= ph == G_HI ? G_ST : G_IDLE;
                tmr     <= ph == G_HI ? TW'(SETTLE - 1) : '0;
                cnt_clk <= 1'b0;
            end else if (ph != G_IDLE) begin
                tmr <= tmr - 1'b1;
            end
        end
    end
endmodule

// File: rtl/ripple_cnt_ctrl.sv
// ripple_cnt_ctrl: start/done sequencer that pulses a ripple JK counter and samples it after settling
// Optional build macro RIPPLE_CNT_CTRL_CHECK_EN adds an increment check on every COUNT sample.
module ripple_cnt_ctrl
    import ripple_cnt_ctrl_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int CNT_W    = 8,
    parameter int PULSE_HI = 1,
    parameter int SETTLE   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] pulses,
    input  logic [WIDTH-1:0] q_in,
    output logic             cnt_clk,
    output logic [WIDTH-1:0] cnt_j,
    output logic [WIDTH-1:0] cnt_k,
    output logic             cnt_rst,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_sample,
    output logic [CNT_W-1:0] pulses_done,
    output logic             wrap,
    output logic             err
);
    localparam logic [CNT_W-1:0] ZLIM = CNT_W'(1 << WIDTH);
    state_t state;
    op_t op_i, op_r;
    logic [CNT_W-1:0] req, pd_nx;
    logic [WIDTH-1:0] jk, jk_v;
    logic run_ok, chk, chk_bad, chk_err, chk_fin, fire, phase_end, sample_now;
    assign op_i   = op_t'(op);
    assign run_ok = op_i != OP_RSVD && (op_i == OP_ZERO || pulses != '0);
    assign jk_v   = run_ok && op_i != OP_HOLD ? '1 : '0;
    assign chk    = state == S_CHECK && sample_now;
    assign pd_nx  = &pulses_done ? pulses_done : pulses_done + 1'b1;
`ifdef RIPPLE_CNT_CTRL_CHECK_EN
    logic [WIDTH-1:0] q_prev;
    assign chk_bad = op_r == OP_COUNT && q_in != q_prev + 1'b1;
    always_ff @(posedge clk) begin
        if (rst)
            q_prev <= '0;
        else if ((state == S_IDLE && start) || chk)
            q_prev <= q_in;
    end
`else
    assign chk_bad = 1'b0;
`endif
    // ZERO gives up once a full counter cycle has gone by without seeing zero
    assign chk_err = (op_r == OP_ZERO && q_in != '0 && pd_nx >= ZLIM) || chk_bad;
    assign chk_fin = chk_err || (op_r == OP_ZERO ? q_in == '0 : pd_nx == req);
    assign fire    = (state == S_IDLE && start && run_ok) || (chk && !chk_fin);
    assign cnt_j   = jk;
    assign cnt_k   = jk;

    ripple_cnt_pulse_gen #(.PULSE_HI(PULSE_HI), .SETTLE(SETTLE)) u_gen (
        .clk        (clk),
        .rst        (rst),
        .fire       (fire),
        .cnt_clk    (cnt_clk),
        .phase_end  (phase_end),
        .sample_now (sample_now)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            op_r        <= OP_COUNT;
            req         <= '0;
            jk          <= '0;
            cnt_rst     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            q_sample    <= '0;
            pulses_done <= '0;
            wrap        <= 1'b0;
            err         <= 1'b0;
        end else begin
            cnt_rst <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op_r        <= op_i;
                    req         <= pulses;
                    jk          <= jk_v;
                    busy        <= 1'b1;
                    pulses_done <= '0;
                    wrap        <= 1'b0;
                    err         <= op_i == OP_RSVD;
                    state       <= run_ok ? S_HIGH : S_FIN;
                end
                S_HIGH:   if (phase_end) state <= S_SETTLE;
                S_SETTLE: if (phase_end) state <= S_CHECK;
                S_CHECK: if (chk) begin
                    q_sample    <= q_in;
                    pulses_done <= pd_nx;
                    if (q_in == '0) wrap <= 1'b1;
                    if (chk_err) err <= 1'b1;
                    if (chk_fin) jk <= '0;
                    state <= chk_fin ? S_FIN : S_HIGH;
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    jk    <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ripple_cnt_ctrl.sv
// tb_ripple_cnt_ctrl: directed bench driving ripple_cnt_ctrl against a behavioural 3-bit ripple counter
module tb_ripple_cnt_ctrl;
    logic clk = 1'b0;
    logic rst, start;
    logic [1:0] op;
    logic [7:0] pulses;
    logic [2:0] q_in;
    logic cnt_clk, cnt_rst, busy, done, wrap, err;
    logic [2:0] cnt_j, cnt_k, q_sample;
    logic [7:0] pulses_done;

    ripple_cnt_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .pulses(pulses), .q_in(q_in),
        .cnt_clk(cnt_clk), .cnt_j(cnt_j), .cnt_k(cnt_k), .cnt_rst(cnt_rst), .busy(busy),
        .done(done), .q_sample(q_sample), .pulses_done(pulses_done), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    // counter model: falling edge of cnt_clk advances when J=K=1, optional stuck/skip faults
    logic [2:0] cnt_q, ld_val;
    logic ld = 1'b0;
    bit stuck = 1'b0;
    int skip_at = 0, nfall = 0, nbase = 0;
    assign q_in = cnt_q;
    always @(negedge cnt_clk or posedge ld) begin
        if (ld) begin
            cnt_q <= ld_val;
        end else begin
            nfall <= nfall + 1;
            if (!stuck && cnt_j[0] && cnt_k[0])
                cnt_q <= cnt_q + ((nfall - nbase + 1 == skip_at) ? 3'd2 : 3'd1);
        end
    end

    int errors = 0, checks = 0, lat;
    bit jk_nz, busy1, seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic [2:0] v);
        ld_val = v;
        ld = 1'b1;
        #1 ld = 1'b0;
    endtask

    task automatic run(input logic [1:0] o, input logic [7:0] n, input bit poke);
        nbase = nfall;
        jk_nz = 0;
        lat = -1;
        @(negedge clk);
        start = 1'b1; op = o; pulses = n;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 400 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) busy1 = busy;
            if (busy && (cnt_j != 3'd0 || cnt_k != 3'd0)) jk_nz = 1;
            if (done) lat = c;
            start = poke && c == 4;
        end
        start = 1'b0;
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; pulses = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt_clk", cnt_clk, 0);
        check("rst_cnt_rst", cnt_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_jk", {cnt_j, cnt_k}, 0);
        check("rst_q", q_sample, 0);
        check("rst_pd", pulses_done, 0);
        check("rst_flags", {wrap, err}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("cnt_rst_low", cnt_rst, 0);

        load(3'd0);
        run(2'b00, 8'd5, 0);
        check("c5_lat", lat, 21);
        check("c5_busy1", busy1, 1);
        check("c5_busy_end", busy, 0);
        check("c5_falls", nfall - nbase, 5);
        check("c5_q", q_sample, 5);
        check("c5_pd", pulses_done, 5);
        check("c5_flags", {wrap, err}, 0);

        load(3'd0);
        run(2'b00, 8'd10, 0);
        check("c10_lat", lat, 41);
        check("c10_q", q_sample, 2);
        check("c10_pd", pulses_done, 10);
        check("c10_wrap", wrap, 1);
        check("c10_err", err, 0);

        load(3'd5);
        run(2'b01, 8'd0, 0);
        check("z5_lat", lat, 13);
        check("z5_falls", nfall - nbase, 3);
        check("z5_q", q_sample, 0);
        check("z5_pd", pulses_done, 3);
        check("z5_flags", {wrap, err}, 2'b10);

        load(3'd3);
        stuck = 1'b1;
        run(2'b01, 8'd0, 0);
        stuck = 1'b0;
        check("zs_lat", lat, 33);
        check("zs_pd", pulses_done, 8);
        check("zs_q", q_sample, 3);
        check("zs_flags", {wrap, err}, 2'b01);

        load(3'd6);
        run(2'b10, 8'd4, 0);
        check("h4_lat", lat, 17);
        check("h4_falls", nfall - nbase, 4);
        check("h4_jk_zero", jk_nz, 0);
        check("h4_q", q_sample, 6);
        check("h4_pd", pulses_done, 4);
        check("h4_flags", {wrap, err}, 0);

        run(2'b11, 8'd5, 0);
        check("rsv_lat", lat, 1);
        check("rsv_err", err, 1);
        check("rsv_falls", nfall - nbase, 0);
        check("rsv_pd", pulses_done, 0);

        run(2'b00, 8'd0, 0);
        check("c0_lat", lat, 1);
        check("c0_err", err, 0);
        check("c0_falls", nfall - nbase, 0);

        load(3'd0);
        run(2'b00, 8'd3, 1);
        check("poke_lat", lat, 13);
        check("poke_pd", pulses_done, 3);
        check("poke_q", q_sample, 3);
        repeat (3) @(posedge clk);
        #1;
        check("poke_idle", busy, 0);

        load(3'd0);
        nbase = nfall;
        @(negedge clk);
        start = 1'b1; op = 2'b00; pulses = 8'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && nfall - nbase < 2; c++) begin
            @(posedge clk); #1;
        end
        check("mid_falls", nfall - nbase, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_busy", busy, 0);
        check("mid_cnt_rst", cnt_rst, 1);
        check("mid_outs", {cnt_clk, cnt_j, cnt_k, done, wrap, err}, 0);
        check("mid_pd", pulses_done, 0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        check("mid_no_done", seen, 0);

`ifdef RIPPLE_CNT_CTRL_CHECK_EN
        load(3'd0);
        skip_at = 3;
        run(2'b00, 8'd6, 0);
        skip_at = 0;
        check("skip_lat", lat, 13);
        check("skip_err", err, 1);
        check("skip_pd", pulses_done, 3);
        check("skip_q", q_sample, 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ripple_cnt_ctrl.md
Name: ripple_cnt_ctrl

Overview:
Synchronous sequencer that drives a WIDTH-bit asynchronous (ripple) JK counter as a resource. It generates the counter's clock pulses and the J/K vectors, waits a settle interval after every falling edge so the ripple can propagate, and samples the counter output. Software-style start/done handshake; sits between the control fabric and the ripple counter instance.

Parameters:
WIDTH, 3, bit width of the controlled ripple counter (q_in, cnt_j, cnt_k, q_sample)
CNT_W, 8, width of the pulse-count request and pulses_done
PULSE_HI, 1, cycles cnt_clk is held high per pulse (>=1)
SETTLE, 2, cycles waited after each cnt_clk falling edge before sampling q_in (>=1)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  reset, synchronous, active-high
start  in  1  request; accepted only in IDLE
op  in  2  00 COUNT, 01 ZERO, 10 HOLD, 11 reserved
pulses  in  CNT_W  pulse count for COUNT/HOLD; captured with start
q_in  in  WIDTH  counter output (ripple, asynchronous to clk)
cnt_clk  out  1  registered clock to counter stage 0 (counter acts on falling edge)
cnt_j  out  WIDTH  J vector to counter
cnt_k  out  WIDTH  K vector to counter
cnt_rst  out  1  counter reset; registered copy of rst
busy  out  1  high from cycle after start accepted until done
done  out  1  one-cycle pulse at end of operation
q_sample  out  WIDTH  last sampled counter value
pulses_done  out  CNT_W  pulses issued in current/last operation
wrap  out  1  sticky per operation: a sample equal to 0 was taken after at least one pulse
err  out  1  sticky per operation: reserved op or ZERO timeout (or check failure, see feature)

Behaviour:
- Reset (rst=1 at posedge): state IDLE; cnt_clk=0, cnt_j=0, cnt_k=0, busy=0, done=0, q_sample=0, pulses_done=0, wrap=0, err=0; cnt_rst=1 the following cycle. Reset mid-operation aborts immediately; no done.
- Outside reset, cnt_rst=0.
- FSM states: IDLE, HIGH, SETTLE, CHECK, FIN.
- IDLE: if start, capture op/pulses; clear pulses_done/wrap/err; go to HIGH. Exceptions: op=11 -> err=1, go to FIN; COUNT/HOLD with pulses=0 -> go to FIN with no pulse. start while busy is ignored.
- J/K during op: COUNT and ZERO -> all ones (toggle); HOLD -> all zeros. Returned to 0 in FIN/IDLE.
- HIGH: cnt_clk=1 for PULSE_HI cycles, then go to SETTLE; cnt_clk=0 from the first SETTLE cycle (falling edge = counter event).
- SETTLE: SETTLE cycles, then go to CHECK.
- CHECK (1 cycle): q_sample<=q_in; pulses_done+1; if q_in==0, wrap=1.
  - COUNT/HOLD: FIN when pulses_done reaches pulses, else HIGH.
  - ZERO: FIN when q_in==0. If 2^WIDTH pulses have been issued without reaching zero, set err=1 and go to FIN.
- ZERO with q_in==0 already at start still issues pulses until zero is sampled again (2^WIDTH pulses). The counter is never assumed cleared by cnt_rst.
- FIN: done=1 for one cycle, busy=0, then go to IDLE. q_sample/pulses_done/wrap/err hold until the next accepted start.
- Per-pulse latency is P = PULSE_HI+SETTLE+1 cycles. done asserts N*P+1 cycles after the start-accept edge for an N-pulse operation.
- pulses_done saturates at the 2^CNT_W-1 width limit. COUNT requests never exceed it, since the request itself is CNT_W wide.

Optional Feature:
RIPPLE_CNT_CTRL_CHECK_EN:
- Defined: in COUNT, each CHECK compares q_in to (previous sample + 1) mod 2^WIDTH. The first comparison is against the value sampled in IDLE on the start cycle. On mismatch: err=1, go to FIN immediately.
- Undefined: no comparison, no IDLE sample register. err is raised only by reserved op or ZERO timeout.

Decomposition:
- Package ripple_cnt_ctrl_pkg: op encodings (OP_COUNT, OP_ZERO, OP_HOLD, OP_RSVD), state enum, per-pulse latency constant helper.
- One natural sub-module: ripple_cnt_pulse_gen. It implements the HIGH/SETTLE down-counter, drives cnt_clk, and signals sample_now. The top holds the FSM, counters and flags.

Test Plan:
- Defaults, counter at 0, COUNT pulses=5 -> 5 falling edges on cnt_clk, done 21 cycles after accept, q_sample=5, pulses_done=5, wrap=0, err=0.
- Counter at 0, COUNT pulses=10 -> q_sample=2, pulses_done=10, wrap=1, err=0.
- Counter at 5, ZERO -> exactly 3 pulses, q_sample=0, pulses_done=3, wrap=1, done after 13 cycles. Counter model stuck at 3 -> err=1 after 8 pulses.
- HOLD pulses=4 with counter at 6 -> cnt_j=cnt_k=0 during op, q_sample=6, pulses_done=4. op=11 -> done next-but-one cycle, err=1, no pulses. COUNT pulses=0 -> done, no pulses, err=0.
- rst asserted mid-COUNT (after 2 pulses) -> next cycle all outputs at reset values, cnt_rst=1, no done. start pulsed while busy -> ignored, pulses_done unchanged.
- With RIPPLE_CNT_CTRL_CHECK_EN, counter model skips a value on pulse 3 of COUNT 6 -> err=1, done right after pulse 3, pulses_done=3.
